// File: rtl/block_interleaver_pp.sv
// Row/column block interleaver (MODE=0) or deinterleaver (MODE=1) with two ping-pong frame banks.
// Optional build macro INTLV_OVF_STATUS_EN adds the ovf_sticky dropped-word status output.
module block_interleaver_pp #(
    parameter int DATA_W = 12,
    parameter int ROWS   = 40,
    parameter int COLS   = 7,
    parameter int MODE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof,
    input  logic              out_ready
`ifdef INTLV_OVF_STATUS_EN
    ,
    output logic              ovf_sticky
`endif
);

    localparam int N  = ROWS * COLS;
    localparam int AW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int PW = RW + CW + AW;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [RW-1:0] R_LAST     = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST     = CW'(COLS - 1);
    localparam logic [AW-1:0] A_STRIDE   = AW'(COLS);
    localparam logic          WR_STRIDED = (MODE != 0);
    localparam logic          RD_STRIDED = (MODE == 0);

    // Advance a (row, col, addr) position; strided walks rows fastest, otherwise columns fastest.
    function automatic logic [PW-1:0] step_pos(input logic strided, input logic [RW-1:0] r,
                                               input logic [CW-1:0] c, input logic [AW-1:0] a);
        logic [RW-1:0] r_n;
        logic [CW-1:0] c_n;
        logic [AW-1:0] a_n;
        r_n = r;
        c_n = c;
        a_n = a + AW'(1);
        if (strided) begin
            if (r == R_LAST) begin
                r_n = {RW{1'b0}};
                if (c == C_LAST) begin
                    c_n = {CW{1'b0}};
                    a_n = {AW{1'b0}};
                end else begin
                    c_n = c + CW'(1);
                    a_n = AW'(c) + AW'(1);
                end
            end else begin
                r_n = r + RW'(1);
                a_n = a + A_STRIDE;
            end
        end else begin
            if (c == C_LAST) begin
                c_n = {CW{1'b0}};
                if (r == R_LAST) begin
                    r_n = {RW{1'b0}};
                    a_n = {AW{1'b0}};
                end else begin
                    r_n = r + RW'(1);
                end
            end else begin
                c_n = c + CW'(1);
            end
        end
        return {r_n, c_n, a_n};
    endfunction

    logic [DATA_W-1:0] mem0 [N];
    logic [DATA_W-1:0] mem1 [N];

    logic [RW-1:0]     wr_r_q, wr_r_d, rd_r_q, rd_r_d;
    logic [CW-1:0]     wr_c_q, wr_c_d, rd_c_q, rd_c_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0][1:0]   st_q, st_d;
    logic              in_ready_q, in_ready_d;
    logic              ra_valid_q, ra_valid_d, ra_bank_q, ra_bank_d;
    logic              ra_sof_q, ra_sof_d, ra_eof_q, ra_eof_d;
    logic [AW-1:0]     ra_addr_q, ra_addr_d;
    logic              out_valid_q, out_valid_d, out_sof_q, out_sof_d;
    logic              out_eof_q, out_eof_d, out_bank_q, out_bank_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] ram_rdata_s;
    logic              wr_fire_s, wr_last_s, rd_last_s;
    logic              out_adv_s, ra_adv_s, iss_fire_s;

    // Frame storage; the arrays carry no reset, the bank states guard their contents.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            if (wr_bank_q) begin
                mem1[wr_addr_q] <= in_data;
            end else begin
                mem0[wr_addr_q] <= in_data;
            end
        end
    end

    assign ram_rdata_s = ra_bank_q ? mem1[ra_addr_q] : mem0[ra_addr_q];

    // Next-state: write walk, read-address issue stage, output stage and bank ownership.
    always_comb begin
        wr_fire_s   = in_valid && in_ready_q;
        wr_last_s   = (wr_r_q == R_LAST) && (wr_c_q == C_LAST);
        rd_last_s   = (rd_r_q == R_LAST) && (rd_c_q == C_LAST);
        out_adv_s   = !out_valid_q || out_ready;
        ra_adv_s    = !ra_valid_q || out_adv_s;
        iss_fire_s  = ra_adv_s && (st_q[rd_bank_q] != ST_EMPTY);
        wr_r_d      = wr_r_q;
        wr_c_d      = wr_c_q;
        wr_addr_d   = wr_addr_q;
        wr_bank_d   = wr_bank_q;
        rd_r_d      = rd_r_q;
        rd_c_d      = rd_c_q;
        rd_addr_d   = rd_addr_q;
        rd_bank_d   = rd_bank_q;
        st_d        = st_q;
        ra_valid_d  = ra_valid_q;
        ra_addr_d   = ra_addr_q;
        ra_bank_d   = ra_bank_q;
        ra_sof_d    = ra_sof_q;
        ra_eof_d    = ra_eof_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        out_bank_d  = out_bank_q;

        if (wr_fire_s) begin
            {wr_r_d, wr_c_d, wr_addr_d} = step_pos(WR_STRIDED, wr_r_q, wr_c_q, wr_addr_q);
            if (wr_last_s) begin
                st_d[wr_bank_q] = ST_FULL;
                wr_bank_d       = ~wr_bank_q;
            end else begin
                wr_bank_d = wr_bank_q;
            end
        end else begin
            wr_bank_d = wr_bank_q;
        end

        // The issue pointer moves to the next bank as soon as its last address leaves, so no read bubble.
        if (iss_fire_s) begin
            ra_valid_d = 1'b1;
            ra_addr_d  = rd_addr_q;
            ra_bank_d  = rd_bank_q;
            ra_sof_d   = (rd_r_q == {RW{1'b0}}) && (rd_c_q == {CW{1'b0}});
            ra_eof_d   = rd_last_s;
            {rd_r_d, rd_c_d, rd_addr_d} = step_pos(RD_STRIDED, rd_r_q, rd_c_q, rd_addr_q);
            if (st_q[rd_bank_q] == ST_FULL) begin
                st_d[rd_bank_q] = ST_DRAIN;
            end else begin
                st_d[rd_bank_q] = st_d[rd_bank_q];
            end
            rd_bank_d = rd_last_s ? ~rd_bank_q : rd_bank_q;
        end else if (ra_adv_s) begin
            ra_valid_d = 1'b0;
        end else begin
            ra_valid_d = ra_valid_q;
        end

        if (out_adv_s) begin
            out_valid_d = ra_valid_q;
            out_sof_d   = ra_valid_q && ra_sof_q;
            out_eof_d   = ra_valid_q && ra_eof_q;
            if (ra_valid_q) begin
                out_data_d = ram_rdata_s;
                out_bank_d = ra_bank_q;
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end

        if (out_valid_q && out_ready && out_eof_q) begin
            st_d[out_bank_q] = ST_EMPTY;
        end else begin
            st_d[out_bank_q] = st_d[out_bank_q];
        end

        in_ready_d = (st_d[wr_bank_d] == ST_EMPTY);
    end

    // State registers; reset discards every frame and restarts both walks at word 0 of B0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_r_q      <= {RW{1'b0}};
            wr_c_q      <= {CW{1'b0}};
            wr_addr_q   <= {AW{1'b0}};
            wr_bank_q   <= 1'b0;
            rd_r_q      <= {RW{1'b0}};
            rd_c_q      <= {CW{1'b0}};
            rd_addr_q   <= {AW{1'b0}};
            rd_bank_q   <= 1'b0;
            st_q        <= {ST_EMPTY, ST_EMPTY};
            in_ready_q  <= 1'b0;
            ra_valid_q  <= 1'b0;
            ra_addr_q   <= {AW{1'b0}};
            ra_bank_q   <= 1'b0;
            ra_sof_q    <= 1'b0;
            ra_eof_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_bank_q  <= 1'b0;
        end else begin
            wr_r_q      <= wr_r_d;
            wr_c_q      <= wr_c_d;
            wr_addr_q   <= wr_addr_d;
            wr_bank_q   <= wr_bank_d;
            rd_r_q      <= rd_r_d;
            rd_c_q      <= rd_c_d;
            rd_addr_q   <= rd_addr_d;
            rd_bank_q   <= rd_bank_d;
            st_q        <= st_d;
            in_ready_q  <= in_ready_d;
            ra_valid_q  <= ra_valid_d;
            ra_addr_q   <= ra_addr_d;
            ra_bank_q   <= ra_bank_d;
            ra_sof_q    <= ra_sof_d;
            ra_eof_q    <= ra_eof_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_bank_q  <= out_bank_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;

`ifdef INTLV_OVF_STATUS_EN
    logic ovf_q, ovf_d;

    // Dropped-word status latches until the next reset.
    always_comb begin
        ovf_d = ovf_q | (in_valid & ~in_ready_q);
    end

    // Status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_sticky = ovf_q;
`endif

endmodule

// File: tb/tb_block_interleaver_pp.sv
// Scoreboard bench: 40x7 interleaver feeding a 40x7 deinterleaver, plus a 4x3 interleaver under backpressure.
module tb_block_interleaver_pp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_in_valid = 1'b0, c_in_valid = 1'b0;
    logic [11:0] a_in_data = 12'd0, c_in_data = 12'd0;
    logic        a_in_ready, a_out_valid, a_out_sof, a_out_eof, a_out_ready;
    logic [11:0] a_out_data, b_out_data, c_out_data;
    logic        b_in_ready, b_out_valid, b_out_sof, b_out_eof;
    logic        b_out_ready = 1'b1;
    logic        c_in_ready, c_out_valid, c_out_sof, c_out_eof, c_out_ready;
    logic        c_rdy_man = 1'b0, c_rdy_rnd = 1'b0, c_rand_en = 1'b0;
    logic        a_ovf, b_ovf, c_ovf;
    int          n_checks = 0, n_pass = 0, n_fail = 0;
    int          a_pos = 0, b_pos = 0, c_pos = 0, c_xfers = 0;
    int          qa[$], qb[$], qc[$];

    assign a_out_ready = b_in_ready;
    assign c_out_ready = c_rand_en ? c_rdy_rnd : c_rdy_man;

    always #5 clk = ~clk;

    block_interleaver_pp #(.DATA_W(12), .ROWS(40), .COLS(7), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_sof(a_out_sof), .out_eof(a_out_eof),
        .out_ready(a_out_ready)
`ifdef INTLV_OVF_STATUS_EN
        , .ovf_sticky(a_ovf)
`endif
    );

    block_interleaver_pp #(.DATA_W(12), .ROWS(40), .COLS(7), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(a_out_valid), .in_data(a_out_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_sof(b_out_sof), .out_eof(b_out_eof),
        .out_ready(b_out_ready)
`ifdef INTLV_OVF_STATUS_EN
        , .ovf_sticky(b_ovf)
`endif
    );

    block_interleaver_pp #(.DATA_W(12), .ROWS(4), .COLS(3), .MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
        .out_valid(c_out_valid), .out_data(c_out_data), .out_sof(c_out_sof), .out_eof(c_out_eof),
        .out_ready(c_out_ready)
`ifdef INTLV_OVF_STATUS_EN
        , .ovf_sticky(c_ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Random downstream readiness for the 4x3 instance.
    always @(posedge clk) c_rdy_rnd <= 1'($urandom_range(0, 1));

    // Scoreboard for the 40x7 interleaver output.
    always @(negedge clk) begin
        if (!rst_n) a_pos <= 0;
        else if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) check("a_extra_word", 32'(a_out_data), 32'hFFFF);
            else begin
                check("a_data", 32'(a_out_data), 32'(qa[0]));
                check("a_sof", 32'(a_out_sof), 32'(a_pos == 0));
                check("a_eof", 32'(a_out_eof), 32'(a_pos == 279));
                void'(qa.pop_front());
            end
            a_pos <= (a_pos == 279) ? 0 : a_pos + 1;
        end
    end

    // Scoreboard for the round trip through the deinterleaver.
    always @(negedge clk) begin
        if (!rst_n) b_pos <= 0;
        else if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) check("b_extra_word", 32'(b_out_data), 32'hFFFF);
            else begin
                check("b_data", 32'(b_out_data), 32'(qb[0]));
                check("b_sof", 32'(b_out_sof), 32'(b_pos == 0));
                check("b_eof", 32'(b_out_eof), 32'(b_pos == 279));
                void'(qb.pop_front());
            end
            b_pos <= (b_pos == 279) ? 0 : b_pos + 1;
        end
    end

    // Scoreboard for the 4x3 interleaver output.
    always @(negedge clk) begin
        if (!rst_n) begin
            c_pos   <= 0;
            c_xfers <= 0;
        end else if (c_out_valid && c_out_ready) begin
            if (qc.size() == 0) check("c_extra_word", 32'(c_out_data), 32'hFFFF);
            else begin
                check("c_data", 32'(c_out_data), 32'(qc[0]));
                check("c_sof", 32'(c_out_sof), 32'(c_pos == 0));
                check("c_eof", 32'(c_out_eof), 32'(c_pos == 11));
                void'(qc.pop_front());
            end
            c_pos   <= (c_pos == 11) ? 0 : c_pos + 1;
            c_xfers <= c_xfers + 1;
        end
    end

    task automatic send_a(input int base, input int count, input bit push);
        if (push) begin
            for (int c = 0; c < 7; c++)
                for (int r = 0; r < 40; r++) qa.push_back(base + r * 7 + c);
            for (int i = 0; i < 280; i++) qb.push_back(base + i);
        end
        for (int i = 0; i < count; i++) begin
            int w = 0;
            a_in_valid = 1'b1;
            a_in_data  = 12'(base + i);
            while (!a_in_ready && w < 2000) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 2000) check("a_in_ready_timeout", 32'(a_in_ready), 32'd1);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
    endtask

    task automatic send_c(input int base, input int count);
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 4; r++) qc.push_back(base + r * 3 + c);
        for (int i = 0; i < count; i++) begin
            int w = 0;
            c_in_valid = 1'b1;
            c_in_data  = 12'(base + i);
            while (!c_in_ready && w < 2000) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 2000) check("c_in_ready_timeout", 32'(c_in_ready), 32'd1);
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int w = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && w < limit) begin
            @(posedge clk); #1;
            w++;
        end
        check(tag, 32'(qa.size() + qb.size() + qc.size()), 32'd0);
    endtask

    initial begin
        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data", 32'(a_out_data), 32'd0);
        check("rst_sof_eof", 32'({a_out_sof, a_out_eof}), 32'd0);
`ifdef INTLV_OVF_STATUS_EN
        check("rst_ovf", 32'(c_ovf), 32'd0);
`endif
        rst_n = 1'b1;
        check("in_ready_before_clk", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        check("in_ready_after_clk", 32'(a_in_ready), 32'd1);

        // One 40x7 frame, then latency of the first output word.
        send_a(0, 280, 1'b1);
        check("lat_cycle0", 32'(a_out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_cycle1", 32'(a_out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_cycle2_valid", 32'(a_out_valid), 32'd1);
        check("lat_cycle2_data", 32'(a_out_data), 32'd0);
        check("lat_cycle2_sof", 32'(a_out_sof), 32'd1);

        // Three back-to-back frames through interleaver and deinterleaver.
        send_a(280, 280, 1'b1);
        send_a(560, 280, 1'b1);
        send_a(840, 280, 1'b1);
        wait_drain("ab_drain", 5000);

        // 4x3 with downstream stalled: both banks fill, then in_ready drops.
        send_c(0, 12);
        send_c(12, 12);
        check("c_full_in_ready", 32'(c_in_ready), 32'd0);
`ifdef INTLV_OVF_STATUS_EN
        check("c_ovf_clear", 32'(c_ovf), 32'd0);
`endif
        c_in_valid = 1'b1;
        c_in_data  = 12'd999;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("c_stall_in_ready", 32'(c_in_ready), 32'd0);
            check("c_stall_valid", 32'(c_out_valid), 32'd1);
            check("c_stall_data", 32'(c_out_data), 32'd0);
            check("c_stall_sof", 32'(c_out_sof), 32'd1);
        end
        c_in_valid = 1'b0;
`ifdef INTLV_OVF_STATUS_EN
        check("c_ovf_set", 32'(c_ovf), 32'd1);
`endif
        c_rdy_man = 1'b1;
        @(posedge clk); #1;
        c_rdy_man = 1'b0;
        @(negedge clk); #1;
        check("c_pulse_xfers", 32'(c_xfers), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("c_hold_data", 32'(c_out_data), 32'd3);
            check("c_hold_valid", 32'(c_out_valid), 32'd1);
            check("c_hold_in_ready", 32'(c_in_ready), 32'd0);
        end

        // Random out_ready drains the rest without loss or duplication.
        c_rand_en = 1'b1;
        wait_drain("c_drain", 3000);
        check("c_total_xfers", 32'(c_xfers), 32'd24);
        check("c_in_ready_after", 32'(c_in_ready), 32'd1);
`ifdef INTLV_OVF_STATUS_EN
        check("c_ovf_sticky", 32'(c_ovf), 32'd1);
`endif

        // Asynchronous reset part-way through a frame.
        send_a(1000, 100, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(a_out_valid), 32'd0);
        check("arst_out_data", 32'(a_out_data), 32'd0);
        check("arst_c_out_data", 32'(c_out_data), 32'd0);
        check("arst_in_ready", 32'(a_in_ready), 32'd0);
`ifdef INTLV_OVF_STATUS_EN
        check("arst_ovf", 32'(c_ovf), 32'd0);
`endif
        qa.delete();
        qb.delete();
        qc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rerst_in_ready", 32'(a_in_ready), 32'd1);
        send_a(1000, 280, 1'b1);
        wait_drain("post_reset_drain", 3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
